// File: rtl/std_issue_arbiter.sv
// std_issue_arbiter: two integer issue ports share one store-data exe unit.
// Each port owns a small circular queue; a round-robin arbiter moves one
// queue head per cycle into a registered output stage feeding fromInt.
// Redirects drop every queued, incoming or staged uop younger than the
// redirect point (or equal to it when level is set).
module std_issue_arbiter #(
  parameter int QDEPTH = 2,
  parameter int ROB_W  = 5,
  parameter int SQ_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_0_valid,
  output logic              io_in_0_ready,
  input  logic [3:0]        io_in_0_bits_uop_ctrl_fuType,
  input  logic [6:0]        io_in_0_bits_uop_ctrl_fuOpType,
  input  logic              io_in_0_bits_uop_robIdx_flag,
  input  logic [ROB_W-1:0]  io_in_0_bits_uop_robIdx_value,
  input  logic              io_in_0_bits_uop_sqIdx_flag,
  input  logic [SQ_W-1:0]   io_in_0_bits_uop_sqIdx_value,
  input  logic [63:0]       io_in_0_bits_src_0,
  input  logic              io_in_1_valid,
  output logic              io_in_1_ready,
  input  logic [3:0]        io_in_1_bits_uop_ctrl_fuType,
  input  logic [6:0]        io_in_1_bits_uop_ctrl_fuOpType,
  input  logic              io_in_1_bits_uop_robIdx_flag,
  input  logic [ROB_W-1:0]  io_in_1_bits_uop_robIdx_value,
  input  logic              io_in_1_bits_uop_sqIdx_flag,
  input  logic [SQ_W-1:0]   io_in_1_bits_uop_sqIdx_value,
  input  logic [63:0]       io_in_1_bits_src_0,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [3:0]        io_out_bits_uop_ctrl_fuType,
  output logic [6:0]        io_out_bits_uop_ctrl_fuOpType,
  output logic              io_out_bits_uop_robIdx_flag,
  output logic [ROB_W-1:0]  io_out_bits_uop_robIdx_value,
  output logic              io_out_bits_uop_sqIdx_flag,
  output logic [SQ_W-1:0]   io_out_bits_uop_sqIdx_value,
  output logic [63:0]       io_out_bits_src_0,
  input  logic              io_redirect_valid,
  input  logic              io_redirect_bits_robIdx_flag,
  input  logic [ROB_W-1:0]  io_redirect_bits_robIdx_value,
  input  logic              io_redirect_bits_level,
  output logic              io_grantPtr
);

  localparam int PW     = $clog2(QDEPTH);
  localparam int CW     = PW + 1;
  localparam int UW     = 4 + 7 + 1 + ROB_W + 1 + SQ_W + 64;
  localparam int RV_LO  = 64 + SQ_W + 1;
  localparam int RF_BIT = RV_LO + ROB_W;

  logic [UW-1:0] inUop     [2];
  logic [1:0]    inValid;
  logic [UW-1:0] mem       [2][QDEPTH];
  logic [PW-1:0] head      [2];
  logic [PW-1:0] tail      [2];
  logic [CW-1:0] count     [2];
  logic [UW-1:0] headUop   [2];
  logic [CW-1:0] kept      [2];
  logic [PW-1:0] writeSlot [2];
  logic [1:0]    cand;
  logic [1:0]    enq;
  logic [1:0]    deq;
  logic          loadStage;
  logic          anyCand;
  logic          grantSel;
  logic          doGrant;
  logic [UW-1:0] grantUop;
  logic          outFlush;
  logic          outValid;
  logic [UW-1:0] outUop;
  logic          grantPtr;

  // Both ports are packed the same way so the queues can share one loop body.
  assign inUop[0] = {io_in_0_bits_uop_ctrl_fuType, io_in_0_bits_uop_ctrl_fuOpType,
                     io_in_0_bits_uop_robIdx_flag, io_in_0_bits_uop_robIdx_value,
                     io_in_0_bits_uop_sqIdx_flag, io_in_0_bits_uop_sqIdx_value,
                     io_in_0_bits_src_0};
  assign inUop[1] = {io_in_1_bits_uop_ctrl_fuType, io_in_1_bits_uop_ctrl_fuOpType,
                     io_in_1_bits_uop_robIdx_flag, io_in_1_bits_uop_robIdx_value,
                     io_in_1_bits_uop_sqIdx_flag, io_in_1_bits_uop_sqIdx_value,
                     io_in_1_bits_src_0};
  assign inValid  = {io_in_1_valid, io_in_0_valid};

  // A uop is flushed when it is younger than the redirect, or equal to it on a level-1 redirect.
  function automatic logic flushHit(input logic [UW-1:0] u);
    logic             uf;
    logic [ROB_W-1:0] uv;
    logic             after;
    uf    = u[RF_BIT];
    uv    = u[RF_BIT-1:RV_LO];
    after = (uf != io_redirect_bits_robIdx_flag) ? (uv < io_redirect_bits_robIdx_value)
                                                 : (uv > io_redirect_bits_robIdx_value);
    return io_redirect_valid & (after | (io_redirect_bits_level &
           (uf == io_redirect_bits_robIdx_flag) & (uv == io_redirect_bits_robIdx_value)));
  endfunction

  // Per-queue view: head candidate and how many age-ordered entries survive the redirect.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      logic          stop;
      logic [PW-1:0] slot;
      stop       = 1'b0;
      slot       = head[p];
      headUop[p] = mem[p][head[p]];
      cand[p]    = (count[p] != '0) && !flushHit(headUop[p]);
      kept[p]    = '0;
      for (int k = 0; k < QDEPTH; k++) begin
        slot = head[p] + PW'(k);
        if (!stop && (CW'(k) < count[p]) && !flushHit(mem[p][slot]))
          kept[p] = kept[p] + CW'(1);
        else
          stop = 1'b1;
      end
      writeSlot[p] = (kept[p] != count[p]) ? head[p] + kept[p][PW-1:0] : tail[p];
      enq[p]       = inValid[p] && (count[p] != CW'(QDEPTH)) && !flushHit(inUop[p]);
    end
  end

  // Round-robin pick between surviving heads whenever the output stage can take a uop.
  always_comb begin
    loadStage = !outValid || io_out_ready;
    anyCand   = cand[0] || cand[1];
    grantSel  = (cand[0] && cand[1]) ? grantPtr : cand[1];
    doGrant   = loadStage && anyCand;
    deq[0]    = doGrant && !grantSel;
    deq[1]    = doGrant && grantSel;
    grantUop  = grantSel ? headUop[1] : headUop[0];
    outFlush  = outValid && flushHit(outUop);
  end

  // Queue pointers: flushed tail entries are rolled back, then dequeue and enqueue apply.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        head[p]  <= '0;
        tail[p]  <= '0;
        count[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        head[p]  <= head[p] + PW'(deq[p]);
        tail[p]  <= writeSlot[p] + PW'(enq[p]);
        count[p] <= kept[p] - CW'(deq[p]) + CW'(enq[p]);
      end
    end
  end

  // Queue storage holds only data, so it needs no reset.
  always_ff @(posedge clock) begin
    for (int p = 0; p < 2; p++)
      if (enq[p]) mem[p][writeSlot[p]] <= inUop[p];
  end

  // Output stage and round-robin pointer; a flushed staged uop is dropped even under backpressure.
  always_ff @(posedge clock) begin
    if (reset) begin
      outValid <= 1'b0;
      outUop   <= '0;
      grantPtr <= 1'b0;
    end else begin
      if (loadStage) begin
        outValid <= anyCand;
        if (anyCand) outUop <= grantUop;
      end else if (outFlush) begin
        outValid <= 1'b0;
      end
      if (doGrant) grantPtr <= ~grantSel;
    end
  end

  assign io_in_0_ready = (count[0] != CW'(QDEPTH));
  assign io_in_1_ready = (count[1] != CW'(QDEPTH));
  assign io_out_valid  = outValid;
  assign io_grantPtr   = grantPtr;
  assign {io_out_bits_uop_ctrl_fuType, io_out_bits_uop_ctrl_fuOpType,
          io_out_bits_uop_robIdx_flag, io_out_bits_uop_robIdx_value,
          io_out_bits_uop_sqIdx_flag, io_out_bits_uop_sqIdx_value,
          io_out_bits_src_0} = outUop;

endmodule
